// File: rtl/gf2_div.sv
// Iterative GF(2) polynomial divider: dividend = quotient*divisor ^ remainder, deg r < deg b.
// Build option GF2_DIV_EARLY_EXIT_EN: leave RUN once the partial remainder drops below deg b.
module gf2_div #(
   parameter int unsigned N = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [N-1:0] dividend,
   input  logic [N-1:0] divisor,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] quotient,
   output logic [N-1:0] remainder,
   output logic         div_zero
);
   localparam int unsigned DW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

   state_t        state;
   logic [N-1:0]  r;
   logic [N-1:0]  q;
   logic [N-1:0]  b;
   logic [N-1:0]  r_nxt;
   logic [N-1:0]  q_nxt;
   logic [DW-1:0] db;
   logic          load_fin;
   logic          step_exit;

   // Index of the highest set bit; zero for a zero operand.
   function automatic logic [DW-1:0] deg(input logic [N-1:0] v);
      logic [DW-1:0] d;
      d = '0;
      for (int i = 0; i < N; i++)
         if (v[i]) d = DW'(i);
      return d;
   endfunction

`ifdef GF2_DIV_EARLY_EXIT_EN
   logic [DW-1:0] dr;
   logic [DW-1:0] dr_nxt;
   logic [DW-1:0] sh;

   // One reduction step aligned on the current remainder degree.
   always_comb begin
      dr    = deg(r);
      r_nxt = r;
      q_nxt = q;
      sh    = '0;
      if (r != '0 && dr >= db) begin
         sh    = dr - db;
         r_nxt = r ^ (b << sh);
         q_nxt = q | (N'(1) << sh);
      end
      dr_nxt    = deg(r_nxt);
      step_exit = (r_nxt == '0) || (dr_nxt < db);
   end

   // Nothing to reduce: results are known at load time.
   assign load_fin = (divisor == '0) || (dividend == '0) || (deg(dividend) < deg(divisor));
`else
   localparam logic [DW:0] LAST = (DW+1)'(N - 1);

   logic [DW-1:0] s;
   logic [DW:0]   idx;
   logic          r_hit;

   // Fixed schedule: shift s walks N-1 down to 0, stepping only where R has the aligned bit.
   always_comb begin
      r_nxt = r;
      q_nxt = q;
      idx   = {1'b0, s} + {1'b0, db};
      r_hit = |(r & (N'(1) << idx));
      if (idx <= LAST && r_hit) begin
         r_nxt = r ^ (b << s);
         q_nxt = q | (N'(1) << s);
      end
      step_exit = (s == '0);
   end

   assign load_fin = (divisor == '0);

   always_ff @(posedge clk) begin
      if (reset)
         s <= '0;
      else if (state == IDLE)
         s <= DW'(N - 1);
      else if (state == RUN)
         s <= s - DW'(1);
   end
`endif

   // Control FSM; results and flags are published together with done.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         quotient  <= '0;
         remainder <= '0;
         div_zero  <= 1'b0;
         r         <= '0;
         q         <= '0;
         b         <= '0;
         db        <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  r        <= dividend;
                  q        <= '0;
                  b        <= divisor;
                  db       <= deg(divisor);
                  div_zero <= 1'b0;
                  busy     <= 1'b1;
                  state    <= load_fin ? FIN : RUN;
               end
            end
            RUN: begin
               r <= r_nxt;
               q <= q_nxt;
               if (step_exit) state <= FIN;
            end
            FIN: begin
               done      <= 1'b1;
               busy      <= 1'b0;
               quotient  <= q;
               remainder <= r;
               div_zero  <= (b == '0);
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_gf2_div.sv
// Bench for gf2_div: long-division reference model with per-cycle compare, plus directed literal vectors.
module tb_gf2_div;
   localparam int unsigned N = 32;
`ifdef GF2_DIV_EARLY_EXIT_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic [N-1:0] dividend;
   logic [N-1:0] divisor;
   logic         busy;
   logic         done;
   logic [N-1:0] quotient;
   logic [N-1:0] remainder;
   logic         div_zero;

   int   total = 0;
   int   bad   = 0;
   logic armed = 1'b0;

   always #5 clk = ~clk;

   gf2_div #(.N(N)) dut (
      .clk(clk), .reset(reset), .start(start), .dividend(dividend), .divisor(divisor),
      .busy(busy), .done(done), .quotient(quotient), .remainder(remainder), .div_zero(div_zero)
   );

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Schoolbook long division over GF(2); returns {q, r}.
   function automatic logic [2*N-1:0] ref_div(input logic [N-1:0] a, input logic [N-1:0] bv);
      logic [N-1:0] qq;
      logic [N-1:0] rr;
      int           dbv;
      qq = '0;
      rr = a;
      if (bv == '0) return {qq, rr};
      dbv = 0;
      for (int i = 0; i < N; i++) if (bv[i]) dbv = i;
      for (int i = N - 1; i >= dbv; i--) begin
         if (rr[i]) begin
            rr = rr ^ (bv << (i - dbv));
            qq = qq | (N'(1) << (i - dbv));
         end
      end
      return {qq, rr};
   endfunction

   function automatic logic [2*N-1:0] clmul(input logic [N-1:0] x, input logic [N-1:0] y);
      logic [2*N-1:0] p;
      p = '0;
      for (int i = 0; i < N; i++) if (y[i]) p = p ^ ({{N{1'b0}}, x} << i);
      return p;
   endfunction

   function automatic logic [N-1:0] topbit(input logic [N-1:0] v);
      logic [N-1:0] t;
      t = '0;
      for (int i = 0; i < N; i++) if (v[i]) t = N'(1) << i;
      return t;
   endfunction

   // Edges from accepting start to the edge after which done is high.
   function automatic int latency(input logic [N-1:0] a, input logic [N-1:0] bv);
      logic [2*N-1:0] qr;
      qr = ref_div(a, bv);
      if (bv == '0) return 1;
      if (EARLY) return 1 + $countones(qr[2*N-1:N]);
      return N + 1;
   endfunction

   // Reference model of the visible outputs.
   logic         m_busy, m_done, m_dz, p_dz;
   logic [N-1:0] m_q, m_r, p_q, p_r, p_a, p_b;
   int           m_left;

   always @(posedge clk) begin
      if (reset) begin
         m_busy <= 1'b0; m_done <= 1'b0; m_dz <= 1'b0;
         m_q <= '0; m_r <= '0; m_left <= 0;
      end else begin
         m_done <= 1'b0;
         if (!m_busy) begin
            if (start) begin
               {p_q, p_r} <= ref_div(dividend, divisor);
               p_a    <= dividend;
               p_b    <= divisor;
               p_dz   <= (divisor == '0);
               m_left <= latency(dividend, divisor);
               m_busy <= 1'b1;
               m_dz   <= 1'b0;
            end
         end else begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
               m_busy <= 1'b0; m_done <= 1'b1;
               m_q <= p_q; m_r <= p_r; m_dz <= p_dz;
            end
         end
      end
   end

   // Per-cycle compare against the model, plus the division identity at each done.
   always @(negedge clk) begin
      if (armed) begin
         check("busy", 64'(busy), 64'(m_busy));
         check("done", 64'(done), 64'(m_done));
         check("quotient", 64'(quotient), 64'(m_q));
         check("remainder", 64'(remainder), 64'(m_r));
         check("div_zero", 64'(div_zero), 64'(m_dz));
         if (done && m_done) begin
            check("identity", clmul(quotient, p_b) ^ {{N{1'b0}}, remainder}, {{N{1'b0}}, p_a});
            if (p_b != '0)
               check("rem_deg", 64'(remainder < topbit(p_b)), 64'(1));
         end
      end
   end

   // Called on a falling edge; returns on the falling edge where done is seen.
   task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] bv, input logic [N-1:0] eq,
                         input logic [N-1:0] er, input logic edz, input int lat_early);
      int cyc;
      int elat;
      elat = EARLY ? lat_early : ((bv == '0) ? 1 : int'(N) + 1);
      dividend = a;
      divisor  = bv;
      start    = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc   = 0;
      while (!done && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      check("done_seen", 64'(done), 64'(1));
      check("latency", 64'(cyc), 64'(elat));
      check("lit_q", 64'(quotient), 64'(eq));
      check("lit_r", 64'(remainder), 64'(er));
      check("lit_dz", 64'(div_zero), 64'(edz));
   endtask

   initial begin
      int dones;
      reset = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
      @(posedge clk);
      armed = 1'b1;
      @(negedge clk);
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_done", 64'(done), 64'(0));
      check("rst_q", 64'(quotient), 64'(0));
      reset = 1'b0;
      @(negedge clk);

      run_op(32'h13, 32'h3, 32'hE, 32'h1, 1'b0, 4);
      run_op(32'h5, 32'h7, 32'h1, 32'h2, 1'b0, 2);
      run_op(32'h3, 32'h5, 32'h0, 32'h3, 1'b0, 1);
      run_op(32'h8, 32'h3, 32'h7, 32'h1, 1'b0, 4);
      run_op(32'hDEADBEEF, 32'h0, 32'h0, 32'hDEADBEEF, 1'b1, 1);
      run_op(32'h0, 32'h7, 32'h0, 32'h0, 1'b0, 1);
      run_op(32'hFFFFFFFF, 32'h80000000, 32'h1, 32'h7FFFFFFF, 1'b0, 2);
      run_op(32'h80000000, 32'h80000001, 32'h1, 32'h1, 1'b0, 2);
      run_op(32'hFFFFFFFF, 32'h1, 32'hFFFFFFFF, 32'h0, 1'b0, 33);

      // Second start while busy must be ignored.
      dividend = 32'h13; divisor = 32'h3; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      dones = 0;
      repeat (2) @(negedge clk);
      dividend = 32'hFF; divisor = 32'h3; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 45; i++) begin
         if (done) dones++;
         @(negedge clk);
      end
      check("one_done", 64'(dones), 64'(1));
      check("busy_q", 64'(quotient), 64'(32'hE));
      check("busy_r", 64'(remainder), 64'(32'h1));

      // Reset five cycles into an operation.
      dividend = 32'hFFFFFFFF; divisor = 32'h1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("abort_busy", 64'(busy), 64'(0));
      check("abort_done", 64'(done), 64'(0));
      check("abort_q", 64'(quotient), 64'(0));
      check("abort_r", 64'(remainder), 64'(0));
      check("abort_dz", 64'(div_zero), 64'(0));
      reset = 1'b0;
      @(negedge clk);
      run_op(32'h13, 32'h3, 32'hE, 32'h1, 1'b0, 4);
      repeat (3) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
